vga_sync_monitor: RTL and testbench

Receive-side checker for the VGA timing produced by the display controller. It samples `hSync`/`vSync` on `ClkPort` and measures line period, hSync pulse width, lines per frame and vSync pulse width. It compares each measurement against the 640x480@60 Hz nominal values, and reports lock, sticky errors and a frame counter. It sits beside the display controller in the VGA top, and its status words can be routed to the seven-segment display for on-board debug.

---
 rtl/vga_sync_monitor.sv | 210 +++++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: measures hSync/vSync periods and pulse widths,
// compares them to nominal values, and reports lock, sticky errors and a frame count.
module vga_sync_monitor #(
  parameter int H_PERIOD    = 3200,
  parameter int H_PULSE     = 384,
  parameter int V_LINES     = 525,
  parameter int V_PULSE     = 2,
  parameter int H_TOL       = 4,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        ClkPort,
  input  logic        Reset,
  input  logic        hSync,
  input  logic        vSync,
  input  logic        err_clear,
  output logic [11:0] h_period,
  output logic [11:0] h_width,
  output logic [9:0]  v_lines,
  output logic [9:0]  v_width,
  output logic [15:0] frame_cnt,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {SEARCH = 2'd0, ACQUIRE = 2'd1, LOCK = 2'd2} state_t;

  localparam logic [11:0] MAX12   = 12'hFFF;
  localparam logic [9:0]  MAX10   = 10'h3FF;
  localparam logic [11:0] HP_MIN  = 12'(H_PERIOD - H_TOL);
  localparam logic [11:0] HP_MAX  = 12'(H_PERIOD + H_TOL);
  localparam logic [11:0] HW_MIN  = 12'(H_PULSE - H_TOL);
  localparam logic [11:0] HW_MAX  = 12'(H_PULSE + H_TOL);
  localparam logic [9:0]  VL_NOM  = 10'(V_LINES);
  localparam logic [9:0]  VP_NOM  = 10'(V_PULSE);
  localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

  logic hs_s1_q, hs_s2_q, hs_prev_q;
  logic vs_s1_q, vs_s2_q, vs_prev_q;

  logic [11:0] h_cnt_q, h_cnt_d, hw_cnt_q, hw_cnt_d;
  logic [11:0] h_period_q, h_period_d, h_width_q, h_width_d;
  logic [9:0]  line_cnt_q, line_cnt_d, vw_cnt_q, vw_cnt_d;
  logic [9:0]  v_lines_q, v_lines_d, v_width_q, v_width_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  good_q, good_d;
  logic        locked_q, locked_d, h_err_q, h_err_d, v_err_q, v_err_d;
  state_t      state_q, state_d;

  logic h_fe, h_re, v_fe, v_re;
  logic h_sat, line_sat, checking, h_viol, v_viol, viol;

  always_comb begin
    h_fe = hs_prev_q & ~hs_s2_q;
    h_re = ~hs_prev_q & hs_s2_q;
    v_fe = vs_prev_q & ~vs_s2_q;
    v_re = ~vs_prev_q & vs_s2_q;

    h_cnt_d     = h_cnt_q;
    hw_cnt_d    = hw_cnt_q;
    h_period_d  = h_period_q;
    h_width_d   = h_width_q;
    line_cnt_d  = line_cnt_q;
    vw_cnt_d    = vw_cnt_q;
    v_lines_d   = v_lines_q;
    v_width_d   = v_width_q;
    frame_cnt_d = frame_cnt_q;
    good_d      = good_q;
    locked_d    = locked_q;
    state_d     = state_q;

    if (h_fe) begin
      h_period_d = (h_cnt_q == MAX12) ? MAX12 : h_cnt_q + 12'd1;
      h_cnt_d    = '0;
    end else if (h_cnt_q != MAX12) begin
      h_cnt_d = h_cnt_q + 12'd1;
    end
    // Saturation means hSync has vanished; flagged for as long as it lasts.
    h_sat = (h_cnt_d == MAX12);

    if (h_re) begin
      h_width_d = hw_cnt_q;
      hw_cnt_d  = '0;
    end else if (!hs_s2_q && hw_cnt_q != MAX12) begin
      hw_cnt_d = hw_cnt_q + 12'd1;
    end

    // A line whose hSync edge coincides with vSync belongs to the new frame.
    if (v_fe) begin
      v_lines_d   = line_cnt_q;
      frame_cnt_d = frame_cnt_q + 16'd1;
      line_cnt_d  = h_fe ? 10'd1 : 10'd0;
    end else if (h_fe && line_cnt_q != MAX10) begin
      line_cnt_d = line_cnt_q + 10'd1;
    end
    line_sat = (line_cnt_d == MAX10);

    if (v_re) begin
      v_width_d = vw_cnt_q;
      vw_cnt_d  = '0;
    end else if (h_fe && !vs_s2_q && vw_cnt_q != MAX10) begin
      vw_cnt_d = vw_cnt_q + 10'd1;
    end

    // Measurements taken while searching may span a partial frame, so only
    // the saturation checks apply there.
    checking = (state_q != SEARCH);
    h_viol = h_sat |
             (checking & ((h_fe & ((h_period_d < HP_MIN) | (h_period_d > HP_MAX))) |
                          (h_re & ((h_width_d < HW_MIN) | (h_width_d > HW_MAX)))));
    v_viol = line_sat |
             (checking & ((v_fe & (v_lines_d != VL_NOM)) |
                          (v_re & (v_width_d != VP_NOM))));
    viol   = h_viol | v_viol;

    h_err_d = h_viol | (h_err_q & ~err_clear);
    v_err_d = v_viol | (v_err_q & ~err_clear);

    case (state_q)
      SEARCH: begin
        if (v_fe && !viol) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      ACQUIRE: begin
        if (viol) begin
          state_d = SEARCH;
          good_d  = '0;
        end else if (v_fe) begin
          good_d = good_q + 8'd1;
          if (good_q + 8'd1 == LOCK_N) begin
            state_d  = LOCK;
            locked_d = 1'b1;
          end
        end
      end
      LOCK: begin
        if (viol) begin
          state_d  = SEARCH;
          locked_d = 1'b0;
          good_d   = '0;
        end
      end
      default: begin
        state_d  = SEARCH;
        locked_d = 1'b0;
        good_d   = '0;
      end
    endcase
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      hs_s1_q     <= 1'b1;
      hs_s2_q     <= 1'b1;
      hs_prev_q   <= 1'b1;
      vs_s1_q     <= 1'b1;
      vs_s2_q     <= 1'b1;
      vs_prev_q   <= 1'b1;
      h_cnt_q     <= '0;
      hw_cnt_q    <= '0;
      h_period_q  <= '0;
      h_width_q   <= '0;
      line_cnt_q  <= '0;
      vw_cnt_q    <= '0;
      v_lines_q   <= '0;
      v_width_q   <= '0;
      frame_cnt_q <= '0;
      good_q      <= '0;
      locked_q    <= 1'b0;
      h_err_q     <= 1'b0;
      v_err_q     <= 1'b0;
      state_q     <= SEARCH;
    end else begin
      hs_s1_q     <= hSync;
      hs_s2_q     <= hs_s1_q;
      hs_prev_q   <= hs_s2_q;
      vs_s1_q     <= vSync;
      vs_s2_q     <= vs_s1_q;
      vs_prev_q   <= vs_s2_q;
      h_cnt_q     <= h_cnt_d;
      hw_cnt_q    <= hw_cnt_d;
      h_period_q  <= h_period_d;
      h_width_q   <= h_width_d;
      line_cnt_q  <= line_cnt_d;
      vw_cnt_q    <= vw_cnt_d;
      v_lines_q   <= v_lines_d;
      v_width_q   <= v_width_d;
      frame_cnt_q <= frame_cnt_d;
      good_q      <= good_d;
      locked_q    <= locked_d;
      h_err_q     <= h_err_d;
      v_err_q     <= v_err_d;
      state_q     <= state_d;
    end
  end

  assign h_period  = h_period_q;
  assign h_width   = h_width_q;
  assign v_lines   = v_lines_q;
  assign v_width   = v_width_q;
  assign frame_cnt = frame_cnt_q;
  assign locked    = locked_q;
  assign h_err     = h_err_q;
  assign v_err     = v_err_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor with scaled-down timing: a frame table drives whole
// frames and queues the report each vSync edge must produce; hand sequences cover the rest.
module tb_vga_sync_monitor;
  localparam int HP  = 40;
  localparam int HW  = 8;
  localparam int VL  = 12;
  localparam int VP  = 2;
  localparam int TOL = 2;

  logic        clk = 1'b0;
  logic        rst, hs, vs, clr;
  logic [11:0] h_period, h_width;
  logic [9:0]  v_lines, v_width;
  logic [15:0] frame_cnt;
  logic        locked, h_err, v_err;
  logic [1:0]  fsm_state;

  vga_sync_monitor #(
    .H_PERIOD(HP), .H_PULSE(HW), .V_LINES(VL), .V_PULSE(VP), .H_TOL(TOL), .LOCK_FRAMES(2)
  ) dut (
    .ClkPort(clk), .Reset(rst), .hSync(hs), .vSync(vs), .err_clear(clr),
    .h_period(h_period), .h_width(h_width), .v_lines(v_lines), .v_width(v_width),
    .frame_cnt(frame_cnt), .locked(locked), .h_err(h_err), .v_err(v_err),
    .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, expected to finish earlier");
    $fatal(1);
  end

  typedef struct packed {
    logic [15:0] frame;
    logic        locked;
    logic        h_err;
    logic        v_err;
    logic [9:0]  v_lines;
    logic [9:0]  v_width;
    logic [11:0] h_period;
    logic [11:0] h_width;
    logic        hp_dc;
  } rep_t;

  typedef struct {
    int   lines;
    int   lp;
    int   lw;
    int   clr_mid;
    rep_t exp;
  } row_t;

  row_t        rows[16];
  rep_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] seen_frame = '0;
  bit          mon_en = 1'b0;

  function automatic rep_t mk(int f, int lk, int he, int ve, int vl, int vw, int hp, int hw);
    rep_t r;
    r.frame    = 16'(f);
    r.locked   = lk[0];
    r.h_err    = he[0];
    r.v_err    = ve[0];
    r.v_lines  = 10'(vl);
    r.v_width  = 10'(vw);
    r.hp_dc    = (hp < 0);
    r.h_period = (hp < 0) ? 12'd0 : 12'(hp);
    r.h_width  = 12'(hw);
    return r;
  endfunction

  function automatic row_t mkrow(int lines, int lp, int lw, int clr_mid, rep_t e);
    row_t r;
    r.lines   = lines;
    r.lp      = lp;
    r.lw      = lw;
    r.clr_mid = clr_mid;
    r.exp     = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // scoreboard: each frame_cnt change is one report from the DUT
  task automatic check_report();
    rep_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_report: got frame_cnt %0d, expected no report", frame_cnt);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("f%0d.frame_cnt", e.frame), frame_cnt, e.frame);
      chk($sformatf("f%0d.locked", e.frame), locked, e.locked);
      chk($sformatf("f%0d.h_err", e.frame), h_err, e.h_err);
      chk($sformatf("f%0d.v_err", e.frame), v_err, e.v_err);
      chk($sformatf("f%0d.v_lines", e.frame), v_lines, e.v_lines);
      chk($sformatf("f%0d.v_width", e.frame), v_width, e.v_width);
      chk($sformatf("f%0d.h_width", e.frame), h_width, e.h_width);
      if (!e.hp_dc) chk($sformatf("f%0d.h_period", e.frame), h_period, e.h_period);
    end
  endtask

  always @(negedge clk) begin
    if (frame_cnt !== seen_frame) begin
      seen_frame = frame_cnt;
      if (mon_en) check_report();
    end
  end

  // driver: one frame, vSync falling together with the first hSync fall
  task automatic drive_frame(input row_t r);
    int per;
    int pw;
    exp_q.push_back(r.exp);
    for (int i = 0; i < r.lines; i++) begin
      per = (i == r.lines - 1) ? r.lp : HP;
      pw  = (i == r.lines - 1) ? r.lw : HW;
      hs  = 1'b0;
      vs  = (i < VP) ? 1'b0 : 1'b1;
      repeat (pw) @(negedge clk);
      hs = 1'b1;
      if (r.clr_mid != 0 && i == r.lines / 2) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (per - pw - 1) @(negedge clk);
      end else begin
        repeat (per - pw) @(negedge clk);
      end
    end
  endtask

  task automatic drive_lines(input int n);
    for (int i = 0; i < n; i++) begin
      hs = 1'b0;
      repeat (HW) @(negedge clk);
      hs = 1'b1;
      repeat (HP - HW) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    hs  = 1'b1;
    vs  = 1'b1;
    clr = 1'b0;

    //                lines  last_per last_pw clr   f  lk he ve  vl  vw  hp  hw
    rows[0]  = mkrow(12, 40, 8,  0, mk(1,  0, 0, 0, 0,  0, -1, 0));
    rows[1]  = mkrow(12, 40, 8,  0, mk(2,  0, 0, 0, 12, 2, 40, 8));
    rows[2]  = mkrow(12, 40, 8,  0, mk(3,  1, 0, 0, 12, 2, 40, 8));
    rows[3]  = mkrow(12, 42, 8,  0, mk(4,  1, 0, 0, 12, 2, 40, 8));
    rows[4]  = mkrow(12, 43, 8,  0, mk(5,  1, 0, 0, 12, 2, 42, 8));
    rows[5]  = mkrow(12, 40, 8,  1, mk(6,  0, 1, 0, 12, 2, 43, 8));
    rows[6]  = mkrow(12, 40, 10, 0, mk(7,  0, 0, 0, 12, 2, 40, 8));
    rows[7]  = mkrow(12, 40, 8,  0, mk(8,  0, 0, 0, 12, 2, 40, 10));
    rows[8]  = mkrow(11, 40, 8,  0, mk(9,  1, 0, 0, 12, 2, 40, 8));
    rows[9]  = mkrow(12, 40, 8,  0, mk(10, 0, 0, 1, 11, 2, 40, 8));
    rows[10] = mkrow(12, 40, 8,  1, mk(11, 0, 0, 1, 12, 2, 40, 8));
    rows[11] = mkrow(12, 40, 11, 0, mk(12, 0, 0, 0, 12, 2, 40, 8));
    rows[12] = mkrow(12, 40, 8,  0, mk(13, 0, 1, 0, 12, 2, 40, 11));
    rows[13] = mkrow(12, 40, 8,  0, mk(1,  0, 0, 0, 0,  0, -1, 0));
    rows[14] = mkrow(12, 40, 8,  0, mk(2,  0, 0, 0, 12, 2, 40, 8));
    rows[15] = mkrow(12, 40, 8,  0, mk(3,  1, 0, 0, 12, 2, 40, 8));

    repeat (3) @(negedge clk);
    chk("reset_h_meas", {h_period, h_width}, 64'd0);
    chk("reset_v_meas", {v_lines, v_width}, 64'd0);
    chk("reset_status", {frame_cnt, locked, h_err, v_err}, 64'd0);
    chk("reset_fsm", fsm_state, 64'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // nominal lock, tolerance edges, wrong frame length, width error
    mon_en = 1'b1;
    for (int i = 0; i < 13; i++) drive_frame(rows[i]);
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    chk("queue_drained_1", exp_q.size(), 64'd0);

    // stuck hSync: clear the old error, then let h_cnt saturate
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (3800) @(negedge clk);
    chk("stuck_before_sat_h_err", h_err, 64'd0);
    repeat (400) @(negedge clk);
    chk("stuck_after_sat_h_err", h_err, 64'd1);
    chk("stuck_locked", locked, 64'd0);
    chk("stuck_fsm_search", fsm_state, 64'd0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clear_vs_violation_h_err", h_err, 64'd1);
    repeat (800) @(negedge clk);

    // mid-frame asynchronous reset
    drive_lines(3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset_h_meas", {h_period, h_width}, 64'd0);
    chk("midreset_v_meas", {v_lines, v_width}, 64'd0);
    chk("midreset_status", {frame_cnt, locked, h_err, v_err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    mon_en = 1'b1;
    for (int i = 13; i < 16; i++) drive_frame(rows[i]);
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    chk("queue_drained_2", exp_q.size(), 64'd0);
    chk("relock_fsm_lock", fsm_state, 64'd2);

    // frame counter wrap
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    vs = 1'b0;
    repeat (2) @(negedge clk);
    vs = 1'b1;
    repeat (6) @(negedge clk);
    chk("frame_cnt_wrap", frame_cnt, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
